// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous front-end for the async SRAM pin wrapper.
//   Turns a level req / one-cycle ack access into timed strobe sequences:
//   read holds oe_n low for RD_WAIT cycles and registers the data; write
//   drives addr/data for WR_SETUP cycles, pulses we_n for WR_PULSE cycles,
//   then holds addr/data for WR_HOLD cycles.
//
// Optional build macro: SRAM_CTRL_DUAL_PORT_EN
//   Adds a second requester (b_* ports) with round-robin arbitration in IDLE.
//   A wins the first tie.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   req/we/addr/din/be    access request (hold stable until ack)
//   ack                   one-cycle completion pulse
//   dout                  registered read data, held until the next read
//   busy                  high whenever the FSM is not idle
//   mem_addr/mem_din      address/data to the wrapper
//   mem_we_n/mem_oe_n     strobes to the wrapper
//   mem_be_n              byte enables to the wrapper (~be)
//   mem_dout              read data from the wrapper
//   b_*                   second requester (dual-port build only)
module sram_ctrl #(
  parameter int AW       = 17,
  parameter int DW       = 16,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [1:0]    be,
  output logic          ack,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  output logic [1:0]    mem_be_n,
  input  logic [DW-1:0] mem_dout
`ifdef SRAM_CTRL_DUAL_PORT_EN
  ,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  input  logic [1:0]    b_be,
  output logic          b_ack,
  output logic [DW-1:0] b_dout
`endif
);

  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("sram_ctrl: RD_WAIT must be >= 1");
  end
  if (WR_PULSE < 1) begin : g_bad_wr_pulse
    $error("sram_ctrl: WR_PULSE must be >= 1");
  end
  if (WR_SETUP < 0 || WR_HOLD < 0) begin : g_bad_wr_phase
    $error("sram_ctrl: WR_SETUP and WR_HOLD must be >= 0");
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The counter is loaded with (cycles-1), so it only needs to reach CMAX-1.
  localparam int CMAX = imax(imax(RD_WAIT, WR_SETUP), imax(WR_PULSE, WR_HOLD));
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] SU_LD = CW'(imax(WR_SETUP - 1, 0));
  localparam logic [CW-1:0] PW_LD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] HD_LD = CW'(imax(WR_HOLD - 1, 0));

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SU, S_WR_PW, S_WR_HD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          ack_nxt, busy_nxt, we_n_nxt, oe_n_nxt;
  logic [DW-1:0] dout_nxt, din_nxt;
  logic [AW-1:0] addr_nxt;
  logic [1:0]    be_n_nxt;
  logic          accept, acked, done, rd_done;

  // Request selected for acceptance this cycle.
  logic          sel_req, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic [1:0]    sel_be;

`ifdef SRAM_CTRL_DUAL_PORT_EN
  logic          sel_port;             // 0 = A, 1 = B
  logic          owner, owner_nxt;     // port that owns the access in flight
  logic          last_grant, last_grant_nxt;
  logic          done_port;
  logic          b_ack_nxt;
  logic [DW-1:0] b_dout_nxt;

  always_comb begin
    sel_port = 1'b0;
    if (req && b_req) sel_port = ~last_grant;
    else if (b_req)   sel_port = 1'b1;
    sel_req  = req | b_req;
    sel_we   = sel_port ? b_we   : we;
    sel_addr = sel_port ? b_addr : addr;
    sel_din  = sel_port ? b_din  : din;
    sel_be   = sel_port ? b_be   : be;
  end

  assign acked = ack | b_ack;
`else
  assign sel_req  = req;
  assign sel_we   = we;
  assign sel_addr = addr;
  assign sel_din  = din;
  assign sel_be   = be;
  assign acked    = ack;
`endif

  // A request is only looked at when idle and not in the ack cycle, which
  // gives the requester one edge to drop or change req after seeing ack.
  assign accept = (state == S_IDLE) && !acked && sel_req;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_be_n   <= 2'b11;
`ifdef SRAM_CTRL_DUAL_PORT_EN
      owner      <= 1'b0;
      last_grant <= 1'b1;
      b_ack      <= 1'b0;
      b_dout     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      dout       <= dout_nxt;
      mem_addr   <= addr_nxt;
      mem_din    <= din_nxt;
      mem_we_n   <= we_n_nxt;
      mem_oe_n   <= oe_n_nxt;
      mem_be_n   <= be_n_nxt;
`ifdef SRAM_CTRL_DUAL_PORT_EN
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      b_ack      <= b_ack_nxt;
      b_dout     <= b_dout_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // be==00 is acknowledged straight from IDLE without touching strobes.
        if (accept && sel_be != 2'b00) begin
          if (!sel_we)           state_nxt = S_RD;
          else if (WR_SETUP > 0) state_nxt = S_WR_SU;
          else                   state_nxt = S_WR_PW;
        end
      end
      S_RD:    if (cnt == '0) state_nxt = S_IDLE;
      S_WR_SU: if (cnt == '0) state_nxt = S_WR_PW;
      S_WR_PW: if (cnt == '0) state_nxt = (WR_HOLD > 0) ? S_WR_HD : S_IDLE;
      S_WR_HD: if (cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    // Counter reloads on every state entry and otherwise counts down to 0.
    cnt_nxt = (cnt != '0) ? cnt - CW'(1) : cnt;
    if (state_nxt != state) begin
      case (state_nxt)
        S_RD:    cnt_nxt = RD_LD;
        S_WR_SU: cnt_nxt = SU_LD;
        S_WR_PW: cnt_nxt = PW_LD;
        S_WR_HD: cnt_nxt = HD_LD;
        default: cnt_nxt = '0;
      endcase
    end

    // Strobes decode the next state, so each is low exactly while in its
    // state and the two can never overlap; the ack cycle leaves both high.
    busy_nxt = (state_nxt != S_IDLE);
    we_n_nxt = (state_nxt != S_WR_PW);
    oe_n_nxt = (state_nxt != S_RD);

    addr_nxt = mem_addr;
    din_nxt  = mem_din;
    be_n_nxt = mem_be_n;
    if (accept) begin
      addr_nxt = sel_addr;
      din_nxt  = sel_din;
      be_n_nxt = ~sel_be;
    end

    done    = (accept && sel_be == 2'b00) || (state != S_IDLE && state_nxt == S_IDLE);
    rd_done = (state == S_RD) && (state_nxt == S_IDLE);

`ifdef SRAM_CTRL_DUAL_PORT_EN
    owner_nxt      = accept ? sel_port : owner;
    last_grant_nxt = accept ? sel_port : last_grant;
    // A be==00 access completes in IDLE, before owner has been updated.
    done_port      = (state == S_IDLE) ? sel_port : owner;
    ack_nxt        = done && !done_port;
    b_ack_nxt      = done && done_port;
    dout_nxt       = (rd_done && !owner) ? mem_dout : dout;
    b_dout_nxt     = (rd_done && owner)  ? mem_dout : b_dout;
`else
    ack_nxt        = done;
    dout_nxt       = rd_done ? mem_dout : dout;
`endif
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM behind the pins.
module tb_sram_ctrl;
  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [1:0]    be = '0;
  logic          ack, busy, mem_we_n, mem_oe_n;
  logic [DW-1:0] dout, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be_n;
`ifdef SRAM_CTRL_DUAL_PORT_EN
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic [1:0]    b_be = '0;
  logic          b_ack;
  logic [DW-1:0] b_dout;
`endif

  sram_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din), .be(be),
    .ack(ack), .dout(dout), .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .mem_be_n(mem_be_n), .mem_dout(mem_dout)
`ifdef SRAM_CTRL_DUAL_PORT_EN
    , .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_be(b_be),
    .b_ack(b_ack), .b_dout(b_dout)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write on any edge with we_n low,
  // combinational read while oe_n low.
  logic [DW-1:0] sram [0:255];
  assign mem_dout = mem_oe_n ? 16'hDEAD : sram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_we_n) begin
      if (!mem_be_n[0]) sram[mem_addr[7:0]][7:0]  <= mem_din[7:0];
      if (!mem_be_n[1]) sram[mem_addr[7:0]][15:8] <= mem_din[15:8];
    end
  end

  logic overlap_seen = 1'b0;
  always @(negedge clk) if (!mem_we_n && !mem_oe_n) overlap_seen = 1'b1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Results of the last access() call; k counts edges after acceptance.
  int         lat, we_lo, oe_lo, we_first, busy_hi;
  logic [1:0] be_n_seen;

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] b);
    req = 1'b1; we = w; addr = a; din = d; be = b;
    lat = -1; we_lo = 0; oe_lo = 0; we_first = -1; busy_hi = 0; be_n_seen = 2'bxx;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      tick();
      if (k == 0) be_n_seen = mem_be_n;
      if (!mem_we_n) begin
        we_lo++;
        if (we_first < 0) we_first = k;
      end
      if (!mem_oe_n) oe_lo++;
      if (busy) busy_hi++;
      if (ack) lat = k;
    end
    req = 1'b0;
    tick();
    chk("ack_one_cycle", ack, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_we_n", mem_we_n, 1);
    chk("rst_oe_n", mem_oe_n, 1);
    chk("rst_be_n", mem_be_n, 2'b11);
    reset_n = 1'b1;

    // 1: full write
    access(1'b1, 17'h00123, 16'hBEEF, 2'b11);
    chk("t1_lat", 32'(lat), 4);
    chk("t1_we_first", 32'(we_first), 1);
    chk("t1_we_lo", 32'(we_lo), 2);
    chk("t1_oe_lo", 32'(oe_lo), 0);
    chk("t1_busy", 32'(busy_hi), 4);
    chk("t1_be_n", be_n_seen, 2'b00);
    chk("t1_mem_addr", mem_addr, 17'h00123);
    chk("t1_mem_din", mem_din, 16'hBEEF);
    chk("t1_dout", dout, 0);

    // 2: read back
    access(1'b0, 17'h00123, 16'h0000, 2'b11);
    chk("t2_lat", 32'(lat), 2);
    chk("t2_oe_lo", 32'(oe_lo), 2);
    chk("t2_we_lo", 32'(we_lo), 0);
    chk("t2_dout", dout, 16'hBEEF);

    // 3: lower-byte write, then read
    access(1'b1, 17'h00123, 16'h1234, 2'b01);
    chk("t3_lat", 32'(lat), 4);
    chk("t3_be_n", be_n_seen, 2'b10);
    chk("t3_we_lo", 32'(we_lo), 2);
    access(1'b0, 17'h00123, 16'h0000, 2'b11);
    chk("t3_dout", dout, 16'hBE34);

    // 4: empty byte mask
    access(1'b1, 17'h00050, 16'hFFFF, 2'b00);
    chk("t4_lat", 32'(lat), 0);
    chk("t4_we_lo", 32'(we_lo), 0);
    chk("t4_oe_lo", 32'(oe_lo), 0);
    chk("t4_busy", 32'(busy_hi), 0);
    chk("t4_dout", dout, 16'hBE34);

    // 5: reset in the middle of the write pulse
    req = 1'b1; we = 1'b1; addr = 17'h00040; din = 16'h5555; be = 2'b11;
    tick();
    tick();
    chk("t5_we_low", mem_we_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_we_async", mem_we_n, 1);
    chk("t5_busy_async", busy, 0);
    req = 1'b0;
    tick();
    chk("t5_no_ack0", ack, 0);
    tick();
    chk("t5_no_ack1", ack, 0);
    chk("t5_dout_rst", dout, 0);
    reset_n = 1'b1;
    tick();
    chk("t5_no_ack2", ack, 0);
    access(1'b0, 17'h00123, 16'h0000, 2'b11);
    chk("t5_rd_lat", 32'(lat), 2);
    chk("t5_rd_dout", dout, 16'hBE34);

`ifdef SRAM_CTRL_DUAL_PORT_EN
    // 6: both ports requesting continuously
    begin
      logic [3:0] seq = '0;
      int         n = 0;
      logic       both = 1'b0;
      req = 1'b1; we = 1'b0; addr = 17'h00123; be = 2'b11;
      b_req = 1'b1; b_we = 1'b0; b_addr = 17'h00123; b_be = 2'b11;
      for (int c = 0; c < 40 && n < 4; c++) begin
        tick();
        if (ack && b_ack) both = 1'b1;
        if (ack) begin seq[n] = 1'b0; n++; end
        else if (b_ack) begin seq[n] = 1'b1; n++; end
      end
      req = 1'b0; b_req = 1'b0;
      tick();
      chk("t6_count", 32'(n), 4);
      chk("t6_order", seq, 4'b1010);
      chk("t6_both", both, 0);
      chk("t6_b_dout", b_dout, 16'hBE34);
    end
`endif

    chk("no_we_oe_overlap", overlap_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
